// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter: grants one of N requesters with a registered one-hot grant,
// a hold limit per grant and one idle turnaround cycle between any two grants.
module rr_decode_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            areset,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] idx_q;
  logic [N-1:0]    grant_q;
  logic            valid_q;
  logic [HW-1:0]   hold_q;

  logic [IDXW-1:0] cand_idx [N];
  logic [N-1:0]    cand_req;
  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic [N-1:0]    win_onehot;
  logic            release_now;

  // Candidate k is requester (ptr+k) mod N; the index width makes the wrap free.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_scan
      assign cand_idx[gi] = ptr_q + IDXW'(gi);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_decode
      assign win_onehot[gi] = (win_idx == IDXW'(gi));
    end
  endgenerate

  assign release_now = done || !req[idx_q] || (hold_q == HOLD_LIMIT);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            idx_q   <= win_idx;
            grant_q <= win_onehot;
            valid_q <= 1'b1;
            hold_q  <= HW'(1);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // Any trigger releases; the forced idle cycle follows from returning to IDLE.
          if (release_now) begin
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= idx_q + IDXW'(1);
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
          idx_q   <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule
